// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - exhaustive built-in self-test sweep and MISR compaction for the alu core
//
// Purpose: on a start request, walks every {opCode, operand1, operand2}
// combination into the ALU and folds each {carryOut, result} response into a
// multiple-input signature register. The final signature stays frozen in DONE
// until start is released.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   level request to run a sweep
//   result       in   ALU result, combinational from the driven operands
//   carryOut     in   ALU carry
//   operand1     out  registered ALU operand 1
//   operand2     out  registered ALU operand 2 (innermost sweep field)
//   opCode       out  registered ALU opcode (outermost sweep field)
//   busy         out  high while sweeping
//   done         out  high while the signature is frozen
//   signature    out  MISR contents
//   expected_sig in   golden signature        (ALU_BIST_COMPARE_EN only)
//   pass         out  signature matched golden (ALU_BIST_COMPARE_EN only)
//
// Optional feature macro: ALU_BIST_COMPARE_EN
// SIG_WIDTH must be at least DATA_WIDTH+1 so the carry has a MISR bit.

module alu_bist #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   SEL_WIDTH  = 4,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SEED       = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  carryOut,
  output logic [DATA_WIDTH-1:0] operand1,
  output logic [DATA_WIDTH-1:0] operand2,
  output logic [SEL_WIDTH-1:0]  opCode,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_WIDTH-1:0]  signature
`ifdef ALU_BIST_COMPARE_EN
  ,
  input  logic [SIG_WIDTH-1:0]  expected_sig,
  output logic                  pass
`endif
);

  localparam int VW = SEL_WIDTH + 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [VW-1:0]         vec, vec_nxt;
  logic [SIG_WIDTH-1:0]  sig, sig_nxt;
  logic [SIG_WIDTH-1:0]  sig_step;
  logic [SIG_WIDTH-1:0]  resp_ext;

  // The three fields form one counter: operand2 in the low bits makes it the
  // fastest-moving field, and the natural carry gives the field wrap order.
  assign {opCode, operand1, operand2} = vec;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign signature = sig;

  // One MISR step absorbing the response to the vector currently driven.
  always_comb begin
    resp_ext                 = '0;
    resp_ext[DATA_WIDTH:0]   = {carryOut, result};
    sig_step = {sig[SIG_WIDTH-2:0], 1'b0}
             ^ (sig[SIG_WIDTH-1] ? POLY : '0)
             ^ resp_ext;
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    sig_nxt   = sig;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        sig_nxt = sig_step;
        // Last vector: stop without advancing so the final vector stays visible.
        if (&vec) state_nxt = DONE;
        else      vec_nxt   = vec + 1'b1;
      end
      DONE: begin
        if (!start) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
          sig_nxt   = SEED;
        end
      end
      default: begin
        state_nxt = IDLE;
        vec_nxt   = '0;
        sig_nxt   = SEED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      vec   <= '0;
      sig   <= SEED;
    end else begin
      state <= state_nxt;
      vec   <= vec_nxt;
      sig   <= sig_nxt;
    end
  end

`ifdef ALU_BIST_COMPARE_EN
  // Verdict is taken from the final MISR step itself, so it is ready on the
  // same edge that raises done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass <= 1'b0;
    end else if (state == RUN && state_nxt == DONE) begin
      pass <= (sig_step == expected_sig);
    end else if (state_nxt == IDLE) begin
      pass <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - self-checking bench for alu_bist on a 2-bit, 1-bit-opcode configuration

module tb_alu_bist;

  localparam int DW = 2;
  localparam int SW = 1;
  localparam int GW = 16;
  localparam int N  = 1 << (2 * DW + SW);
  localparam logic [GW-1:0] POLY = 16'h1021;
  localparam logic [GW-1:0] SEED = 16'hFFFF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] result;
  logic          carryOut;
  logic [DW-1:0] operand1;
  logic [DW-1:0] operand2;
  logic [SW-1:0] opCode;
  logic          busy;
  logic          done;
  logic [GW-1:0] signature;
  logic [GW-1:0] exp_sig = '0;
`ifdef ALU_BIST_COMPARE_EN
  logic          pass;
`endif

  logic          stuck = 1'b0;
  int            total = 0;
  int            bad   = 0;
  logic [GW-1:0] gold;

  always #5 clk = ~clk;

  // Reference ALU: op 0 is add with carry, op 1 is subtract with borrow.
  function automatic logic [DW:0] alu_resp(int op, int a, int b, logic stk);
    int r;
    if (op == 0) r = a + b;
    else         r = (a - b) & ((1 << (DW + 1)) - 1);
    if (stk) r = r & ~1;
    return r[DW:0];
  endfunction

  function automatic logic [GW-1:0] misr(logic [GW-1:0] s, logic [DW:0] resp);
    int v;
    v = (int'(s) * 2) % 65536;
    if (s >= 16'h8000) v = v ^ int'(POLY);
    v = v ^ int'(resp);
    return v[GW-1:0];
  endfunction

  function automatic logic [GW-1:0] golden_sig(logic stk);
    logic [GW-1:0] s;
    s = SEED;
    for (int op = 0; op < (1 << SW); op++)
      for (int a = 0; a < (1 << DW); a++)
        for (int b = 0; b < (1 << DW); b++)
          s = misr(s, alu_resp(op, a, b, stk));
    return s;
  endfunction

  assign {carryOut, result} = alu_resp(int'(opCode), int'(operand1), int'(operand2), stuck);

  alu_bist #(
    .DATA_WIDTH(DW),
    .SEL_WIDTH (SW),
    .SIG_WIDTH (GW),
    .POLY      (POLY),
    .SEED      (SEED)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .result   (result),
    .carryOut (carryOut),
    .operand1 (operand1),
    .operand2 (operand2),
    .opCode   (opCode),
    .busy     (busy),
    .done     (done),
    .signature(signature)
`ifdef ALU_BIST_COMPARE_EN
    ,
    .expected_sig(exp_sig),
    .pass        (pass)
`endif
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_ne(string name, logic [31:0] act, logic [31:0] avoid);
    total++;
    if (act === avoid) begin
      bad++;
      $display("FAIL %s: got %0h must differ from %0h", name, act, avoid);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 sweeping vector m_k, 2 holding result.
  int            m_state = 0;
  int            m_k     = 0;
  logic [GW-1:0] m_sig   = SEED;
  logic          m_pass  = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_state = 0; m_k = 0; m_sig = SEED; m_pass = 1'b0;
      end else begin
        case (m_state)
          0: if (start) m_state = 1;
          1: begin
            m_sig = misr(m_sig, alu_resp(m_k / (1 << (2 * DW)), (m_k / (1 << DW)) % (1 << DW),
                                         m_k % (1 << DW), stuck));
            if (m_k == N - 1) begin
              m_state = 2;
              m_pass  = (m_sig == exp_sig);
            end else begin
              m_k = m_k + 1;
            end
          end
          default: if (!start) begin
            m_state = 0; m_k = 0; m_sig = SEED; m_pass = 1'b0;
          end
        endcase
      end
    end
  end

  // Compare process: every falling edge, DUT against model; also measures run length.
  int busy_cnt = 0;
  int last_len = -1;
  logic prev_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vec", 32'({opCode, operand1, operand2}), 32'd0);
        check("rst_sig", 32'(signature), 32'(SEED));
        busy_cnt = 0;
      end else begin
        check("busy", 32'(busy), 32'(m_state == 1));
        check("done", 32'(done), 32'(m_state == 2));
        check("opCode", 32'(opCode), 32'(m_k / (1 << (2 * DW))));
        check("operand1", 32'(operand1), 32'((m_k / (1 << DW)) % (1 << DW)));
        check("operand2", 32'(operand2), 32'(m_k % (1 << DW)));
        check("signature", 32'(signature), 32'(m_sig));
`ifdef ALU_BIST_COMPARE_EN
        check("pass", 32'(pass), 32'(m_pass));
`endif
        if (busy) busy_cnt++;
        if (done && !prev_done) begin
          check("run_len", 32'(busy_cnt), 32'(N));
          last_len = busy_cnt;
          busy_cnt = 0;
        end
      end
      prev_done = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_done: got done=%0d want 1 within %0d cycles", done, budget);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    gold    = golden_sig(1'b0);
    exp_sig = gold;

    // Pin the model with hand-computed values.
    check("pin_misr", 32'(misr(16'hFFFF, 3'd0)), 32'h0000EFDF);
    check("pin_alu_sub", 32'(alu_resp(1, 0, 1, 1'b0)), 32'h7);
    check("pin_alu_add", 32'(alu_resp(0, 3, 2, 1'b0)), 32'h5);

    repeat (3) step();
    reset_n = 1'b1;
    @(negedge clk);
    check("busy_before_edge", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_first", 32'(busy), 32'd1);
    check("sig_first", 32'(signature), 32'h0000FFFF);
    @(negedge clk);
    check("sig_vec0", 32'(signature), 32'h0000EFDF);
    check("op2_vec1", 32'(operand2), 32'd1);
    @(negedge clk);
    check("sig_vec1", 32'(signature), 32'h0000CF9E);
    check("op2_vec2", 32'(operand2), 32'd2);

    wait_done(60);
    check("sig_golden", 32'(signature), 32'(gold));
    check("last_vec", 32'({opCode, operand1, operand2}), 32'(N - 1));
`ifdef ALU_BIST_COMPARE_EN
    check("pass_golden", 32'(pass), 32'd1);
`endif
    repeat (100) step();
    check("done_held", 32'(done), 32'd1);
    check("sig_held", 32'(signature), 32'(gold));

    start = 1'b0;
    step();
    @(negedge clk);
    check("done_exit", 32'(done), 32'd0);
    check("sig_cleared", 32'(signature), 32'(SEED));

    // Abort at RUN cycle 10, then restart.
    start = 1'b1;
    repeat (11) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    last_len = -1;
    wait_done(60);
    check("restart_sig", 32'(signature), 32'(gold));
    check("restart_len", 32'(last_len), 32'(N));
    start = 1'b0;
    repeat (2) step();

    // Start dropped mid-run: sweep still completes, then back to idle.
    start = 1'b1;
    repeat (6) step();
    start = 1'b0;
    wait_done(60);
    check("drop_done", 32'(done), 32'd1);
    check("drop_sig", 32'(signature), 32'(gold));
    step();
    @(negedge clk);
    check("drop_idle_done", 32'(done), 32'd0);
    check("drop_idle_busy", 32'(busy), 32'd0);

    // result[0] stuck at 0.
    stuck = 1'b1;
    start = 1'b1;
    wait_done(60);
    check_ne("fault_differs", 32'(signature), 32'(gold));
    check("fault_sig_model", 32'(signature), 32'(golden_sig(1'b1)));
`ifdef ALU_BIST_COMPARE_EN
    check("pass_fault", 32'(pass), 32'd0);
`endif
    start = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
